psum_requant_acc: RTL and testbench

- Sits directly downstream of the 128-input pipelined adder tree. Consumes one 32-bit signed partial dot product per cycle.
- Accumulates partial sums over a configured number of K-tiles per output channel. Adds a bias, then requantizes with a rounding arithmetic right shift and saturation to signed 4-bit.
- Emits results on a valid/ready stream toward the activation write-back buffer.
- Flow control: the adder tree cannot stall. The upstream controller therefore gates issue with in_ready and delays its issue strobe by the tree latency to form sum_valid.

---
 rtl/psum_requant_acc_pkg.sv | 47 ++++
 rtl/psum_requant_acc_requant.sv | 24 ++
 rtl/psum_requant_acc.sv | 166 ++++++++++++++++
 tb/tb_psum_requant_acc.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/psum_requant_acc_pkg.sv
// Shared quantisation constants, controller state encoding and the requant
// function (bias add, rounding arithmetic shift, clamp to signed OUT_W).
package pkg_qnt;

  localparam int ACC_W = 40;
  localparam int OUT_W = 4;
  localparam logic signed [OUT_W-1:0] QMIN = -4'sd8;
  localparam logic signed [OUT_W-1:0] QMAX = 4'sd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [OUT_W-1:0] q;
    logic [ACC_W-1:0] raw;
    logic             sat;
  } rq_t;

  // Rounding is done one bit wider than the accumulator so adding the
  // half-LSB can never wrap a value sitting near the positive limit.
  function automatic rq_t requant(input logic signed [ACC_W-1:0] s,
                                  input logic signed [ACC_W-1:0] bias,
                                  input logic [4:0]              shift);
    logic signed [ACC_W-1:0] t;
    logic signed [ACC_W:0]   rnd;
    logic signed [ACC_W:0]   y;
    logic signed [ACC_W:0]   hi;
    logic signed [ACC_W:0]   lo;
    rq_t                     r;
    t   = s + bias;
    rnd = '0;
    if (shift != 5'd0) rnd[shift - 5'd1] = 1'b1;
    y   = ($signed({t[ACC_W-1], t}) + rnd) >>> shift;
    hi  = (ACC_W+1)'(QMAX);
    lo  = (ACC_W+1)'(QMIN);
    r.raw = t;
    r.sat = (y > hi) || (y < lo);
    if (y > hi)      r.q = QMAX;
    else if (y < lo) r.q = QMIN;
    else             r.q = y[OUT_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/psum_requant_acc_requant.sv
// Combinational requantiser: raw = s + bias, q = clamp(round(raw >>> shift)).
// Kept standalone so the activation unit can reuse it.
module qnt_requant
  import pkg_qnt::*;
(
  input  logic signed [ACC_W-1:0] s_i,
  input  logic signed [ACC_W-1:0] bias_i,
  input  logic [4:0]              shift_i,
  output logic signed [OUT_W-1:0] q_o,
  output logic signed [ACC_W-1:0] raw_o,
  output logic                    sat_o
);

  rq_t res;

  always_comb begin
    res = requant(s_i, bias_i, shift_i);
  end

  assign q_o   = $signed(res.q);
  assign raw_o = $signed(res.raw);
  assign sat_o = res.sat;

endmodule

// File: rtl/psum_requant_acc.sv
// K-tile partial-sum accumulator with bias, requantisation and a single
// output register on a valid/ready stream. ACC_W/OUT_W come from pkg_qnt.
module psum_requant_acc
  import pkg_qnt::*;
#(
  parameter int IN_W   = 32,
  parameter int TILE_W = 8,
  parameter int OCH_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_start,
  input  logic [TILE_W-1:0]       cfg_num_tiles,
  input  logic [OCH_W-1:0]        cfg_num_outputs,
  input  logic signed [IN_W-1:0]  cfg_bias,
  input  logic [4:0]              cfg_shift,
  input  logic signed [IN_W-1:0]  sum_in,
  input  logic                    sum_valid,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_q,
  output logic signed [ACC_W-1:0] out_raw,
  output logic                    out_sat,
  output logic                    busy,
  output logic                    done
);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [TILE_W-1:0]       tile_cnt_q, tile_cnt_d;
  logic [OCH_W-1:0]        och_cnt_q, och_cnt_d;
  logic [TILE_W-1:0]       num_tiles_q, num_tiles_d;
  logic [OCH_W-1:0]        num_outs_q, num_outs_d;
  logic signed [IN_W-1:0]  bias_q, bias_d;
  logic [4:0]              shift_q, shift_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_q_q, out_q_d;
  logic signed [ACC_W-1:0] out_raw_q, out_raw_d;
  logic                    out_sat_q, out_sat_d;
  logic                    done_q, done_d;

  logic signed [ACC_W-1:0] sum_ext;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [OUT_W-1:0] rq_q;
  logic signed [ACC_W-1:0] rq_raw;
  logic                    rq_sat;
  logic                    beat;
  logic                    final_beat;
  logic                    last_out;
  logic                    out_hs;

  assign sum_ext  = {{(ACC_W-IN_W){sum_in[IN_W-1]}}, sum_in};
  assign bias_ext = {{(ACC_W-IN_W){bias_q[IN_W-1]}}, bias_q};
  assign acc_sum  = acc_q + sum_ext;

  qnt_requant u_requant (
    .s_i     (acc_sum),
    .bias_i  (bias_ext),
    .shift_i (shift_q),
    .q_o     (rq_q),
    .raw_o   (rq_raw),
    .sat_o   (rq_sat)
  );

  // The adder tree cannot stall, so readiness only depends on whether the
  // output register will have room after this cycle.
  assign in_ready   = (state_q == ACCUM) && (!out_valid_q || out_ready);
  assign beat       = sum_valid && in_ready;
  assign final_beat = (tile_cnt_q == num_tiles_q - 1'b1);
  assign last_out   = (och_cnt_q == num_outs_q - 1'b1);
  assign out_hs     = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    tile_cnt_d  = tile_cnt_q;
    och_cnt_d   = och_cnt_q;
    num_tiles_d = num_tiles_q;
    num_outs_d  = num_outs_q;
    bias_d      = bias_q;
    shift_d     = shift_q;
    out_valid_d = out_hs ? 1'b0 : out_valid_q;
    out_q_d     = out_q_q;
    out_raw_d   = out_raw_q;
    out_sat_d   = out_sat_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          num_tiles_d = (cfg_num_tiles == '0) ? TILE_W'(1) : cfg_num_tiles;
          num_outs_d  = (cfg_num_outputs == '0) ? OCH_W'(1) : cfg_num_outputs;
          bias_d      = cfg_bias;
          shift_d     = cfg_shift;
          acc_d       = '0;
          tile_cnt_d  = '0;
          och_cnt_d   = '0;
          state_d     = ACCUM;
        end
      end
      ACCUM: begin
        if (beat && final_beat) begin
          out_q_d     = rq_q;
          out_raw_d   = rq_raw;
          out_sat_d   = rq_sat;
          out_valid_d = 1'b1;
          acc_d       = '0;
          tile_cnt_d  = '0;
          och_cnt_d   = och_cnt_q + 1'b1;
          if (last_out) state_d = DRAIN;
        end else if (beat) begin
          acc_d      = acc_sum;
          tile_cnt_d = tile_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (out_hs) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      tile_cnt_q  <= '0;
      och_cnt_q   <= '0;
      num_tiles_q <= '0;
      num_outs_q  <= '0;
      bias_q      <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_q_q     <= '0;
      out_raw_q   <= '0;
      out_sat_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      tile_cnt_q  <= tile_cnt_d;
      och_cnt_q   <= och_cnt_d;
      num_tiles_q <= num_tiles_d;
      num_outs_q  <= num_outs_d;
      bias_q      <= bias_d;
      shift_q     <= shift_d;
      out_valid_q <= out_valid_d;
      out_q_q     <= out_q_d;
      out_raw_q   <= out_raw_d;
      out_sat_q   <= out_sat_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_q     = out_q_q;
  assign out_raw   = out_raw_q;
  assign out_sat   = out_sat_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_psum_requant_acc.sv
// Directed plus randomised jobs checked against an arithmetic reference:
// each output is requant(sum of its tile group + bias) computed with longints.
module tb_psum_requant_acc;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_start;
  logic [7:0]         cfg_num_tiles;
  logic [7:0]         cfg_num_outputs;
  logic signed [31:0] cfg_bias;
  logic [4:0]         cfg_shift;
  logic signed [31:0] sum_in;
  logic               sum_valid;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic signed [3:0]  out_q;
  logic signed [39:0] out_raw;
  logic               out_sat;
  logic               busy;
  logic               done;

  int checks   = 0;
  int failures = 0;

  int     beatQ[$];
  longint expQ[$];
  longint expRaw[$];
  longint expSat[$];

  always #5 clk = ~clk;

  psum_requant_acc dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_start       (cfg_start),
    .cfg_num_tiles   (cfg_num_tiles),
    .cfg_num_outputs (cfg_num_outputs),
    .cfg_bias        (cfg_bias),
    .cfg_shift       (cfg_shift),
    .sum_in          (sum_in),
    .sum_valid       (sum_valid),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_q           (out_q),
    .out_raw         (out_raw),
    .out_sat         (out_sat),
    .busy            (busy),
    .done            (done)
  );

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: expected outputs straight from the arithmetic definition.
  task automatic buildExpected(input int nt, input int no, input int bias, input int shift);
    longint t, y, q;
    expQ.delete(); expRaw.delete(); expSat.delete();
    for (int o = 0; o < no; o++) begin
      t = longint'(bias);
      for (int k = 0; k < nt; k++) t += longint'(beatQ[o*nt + k]);
      y = (shift == 0) ? t : ((t + (64'sd1 <<< (shift - 1))) >>> shift);
      q = (y > 7) ? 7 : ((y < -8) ? -8 : y);
      expQ.push_back(q);
      expRaw.push_back(t);
      expSat.push_back((y != q) ? 1 : 0);
    end
  endtask

  // mode 0: out_ready high; 1: random ready and gaps; 2: hold ready low 4 cycles after first result
  task automatic applyStimulus(input int tiles, input int outs, input int bias,
                               input int shift, input int mode);
    int nt, no, nBeats, issued, got, cyc, stall;
    bit expValid, sawFirst, inRdyExp, hs, finalBeat, lastHs;
    nt = (tiles == 0) ? 1 : tiles;
    no = (outs == 0) ? 1 : outs;
    nBeats = nt * no;
    buildExpected(nt, no, bias, shift);
    issued = 0; got = 0; cyc = 0; stall = 0;
    expValid = 1'b0; sawFirst = 1'b0;
    cfg_num_tiles   = 8'(tiles);
    cfg_num_outputs = 8'(outs);
    cfg_bias        = bias;
    cfg_shift       = 5'(shift);
    cfg_start       = 1'b1;
    sum_valid       = 1'b0;
    out_ready       = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    while (got < no && cyc < 4000) begin
      checkOutput("out_valid", out_valid, expValid);
      if (expValid) begin
        checkOutput("out_q", out_q, expQ[0]);
        checkOutput("out_raw", out_raw, expRaw[0]);
        checkOutput("out_sat", out_sat, expSat[0]);
      end
      if (mode == 0)      out_ready = 1'b1;
      else if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (stall > 0) begin out_ready = 1'b0; stall--; end
      else                out_ready = 1'b1;
      cfg_start       = ($urandom_range(0, 3) == 0);
      cfg_num_tiles   = 8'($urandom);
      cfg_num_outputs = 8'($urandom);
      cfg_bias        = $urandom;
      cfg_shift       = 5'($urandom);
      inRdyExp = (issued < nBeats) && (!expValid || out_ready);
      #1;
      checkOutput("in_ready", in_ready, inRdyExp);
      sum_valid = inRdyExp && ((mode != 1) || ($urandom_range(0, 3) != 0));
      sum_in    = (issued < nBeats) ? beatQ[issued] : 32'sd0;
      hs = expValid && out_ready;
      lastHs = 1'b0;
      if (hs) begin
        void'(expQ.pop_front()); void'(expRaw.pop_front()); void'(expSat.pop_front());
        got++;
        lastHs = (got == no);
      end
      finalBeat = sum_valid && ((issued % nt) == nt - 1);
      if (sum_valid) issued++;
      if (finalBeat) expValid = 1'b1;
      else if (hs)   expValid = 1'b0;
      if (mode == 2 && finalBeat && !sawFirst) begin sawFirst = 1'b1; stall = 4; end
      @(posedge clk); #1;
      checkOutput("done", done, lastHs);
      checkOutput("busy", busy, (got < no) ? 1 : 0);
      cyc++;
    end
    cfg_start = 1'b0;
    sum_valid = 1'b0;
    out_ready = 1'b1;
    checkOutput("job_results", got, no);
    @(posedge clk); #1;
    checkOutput("done_pulse_end", done, 0);
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_out_valid", out_valid, 0);
  endtask

  initial begin
    int tiles, outs, bias, shift;
    bit big;
    rst = 1'b1; cfg_start = 1'b0; cfg_num_tiles = '0; cfg_num_outputs = '0;
    cfg_bias = '0; cfg_shift = '0; sum_in = '0; sum_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_out_raw", out_raw, 0);
    checkOutput("reset_out_q", out_q, 0);
    checkOutput("reset_out_sat", out_sat, 0);

    beatQ = '{3, 4};          applyStimulus(2, 1, 0, 0, 0);
    beatQ = '{5, 4};          applyStimulus(2, 1, 0, 0, 0);
    beatQ = '{-20, 0};        applyStimulus(2, 1, 0, 0, 0);
    beatQ = '{-10};           applyStimulus(1, 1, 0, 2, 0);
    beatQ = '{5};             applyStimulus(1, 1, 4, 2, 0);
    beatQ = '{1, 2, 3};       applyStimulus(1, 3, 0, 0, 2);
    beatQ = '{-3, 2};         applyStimulus(0, 0, 1, 0, 0);
    beatQ.delete();
    for (int i = 0; i < 255; i++) beatQ.push_back(32'h7FFF_FFFF);
    applyStimulus(255, 1, 0, 31, 0);

    // Reset in the middle of a job must discard the partial accumulation.
    cfg_num_tiles = 8'd2; cfg_num_outputs = 8'd1; cfg_bias = 0; cfg_shift = 0;
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0; sum_valid = 1'b1; sum_in = 32'sd100;
    @(posedge clk); #1;
    sum_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 0);
    checkOutput("midrst_done", done, 0);
    beatQ = '{6};             applyStimulus(1, 1, 0, 0, 0);

    for (int j = 0; j < 8; j++) begin
      big   = 1'($urandom_range(0, 1));
      tiles = $urandom_range(0, 5);
      outs  = $urandom_range(0, 4);
      bias  = big ? int'($urandom) : $urandom_range(0, 64) - 32;
      shift = big ? $urandom_range(0, 31) : $urandom_range(0, 4);
      beatQ.delete();
      for (int i = 0; i < ((tiles == 0) ? 1 : tiles) * ((outs == 0) ? 1 : outs); i++)
        beatQ.push_back(big ? int'($urandom) : $urandom_range(0, 40) - 20);
      applyStimulus(tiles, outs, bias, shift, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
